// File: rtl/eth_avalon_pkt_fifo.sv
// Packet-aware show-ahead FIFO: words become readable only after commit, can be rolled back by discard.
// Commit-to-q latency is 2 edges when empty; writes are dropped at full and poison the packet; flags are registered.
module eth_avalon_pkt_fifo #(
  parameter  int DEPTH    = 1024,
  parameter  int WIDTH    = 36,
  parameter  int AF_LEVEL = DEPTH - 16,
  parameter  int AE_LEVEL = 16,
  localparam int WIDTHU   = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              aclr,
  input  logic [WIDTH-1:0]  data,
  input  logic              wrreq,
  input  logic              commit,
  input  logic              discard,
  input  logic              rdreq,
  output logic [WIDTH-1:0]  q,
  output logic              rdempty,
  output logic [WIDTHU-1:0] rdusedw,
  output logic [WIDTHU-1:0] wrusedw,
  output logic              wrfull,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic [15:0]       drop_cnt
);

  localparam int AW = WIDTHU - 1;
  localparam logic [WIDTHU-1:0] DEPTH_U = WIDTHU'(DEPTH);
  localparam logic [WIDTHU-1:0] AF_U    = WIDTHU'(AF_LEVEL);
  localparam logic [WIDTHU-1:0] AE_U    = WIDTHU'(AE_LEVEL);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [WIDTHU-1:0] rd_ptr, cm_ptr, wr_ptr;
  logic [WIDTHU-1:0] rd_ptr_n, cm_ptr_n, wr_ptr_n, fetch_ptr;
  logic [WIDTHU-1:0] wrusedw_n, rdusedw_n;
  logic              head_vld, head_vld_n, pop, load;
  logic              wr_acc, ovf_set, drop, overflow_n;

  // rd_ptr addresses the head word, which stays counted as occupied until popped
  always_comb begin
    head_vld   = ~rdempty;
    pop        = rdreq & head_vld;
    wr_acc     = wrreq & ~wrfull & ~overflow;
    ovf_set    = wrreq & wrfull;
    drop       = discard | (commit & (overflow | ovf_set));
    fetch_ptr  = rd_ptr + WIDTHU'(head_vld);
    load       = (~head_vld | pop) & (cm_ptr != fetch_ptr);
    rd_ptr_n   = rd_ptr + WIDTHU'(pop);
    head_vld_n = (head_vld & ~pop) | load;
    wr_ptr_n   = wr_ptr + WIDTHU'(wr_acc);
    cm_ptr_n   = cm_ptr;
    overflow_n = overflow | ovf_set;
    if (drop) begin
      wr_ptr_n   = cm_ptr;
      overflow_n = 1'b0;
    end else if (commit) begin
      cm_ptr_n   = wr_ptr + WIDTHU'(wr_acc);
      overflow_n = 1'b0;
    end
    wrusedw_n = wr_ptr_n - rd_ptr_n;
    rdusedw_n = cm_ptr_n - rd_ptr_n - WIDTHU'(head_vld_n);
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr[AW-1:0]] <= data;
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      rd_ptr       <= '0;
      cm_ptr       <= '0;
      wr_ptr       <= '0;
      q            <= '0;
      rdempty      <= 1'b1;
      rdusedw      <= '0;
      wrusedw      <= '0;
      wrfull       <= 1'b0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      drop_cnt     <= '0;
    end else begin
      rd_ptr       <= rd_ptr_n;
      cm_ptr       <= cm_ptr_n;
      wr_ptr       <= wr_ptr_n;
      // fetch_ptr always lies below cm_ptr here, so it never collides with this edge's write
      if (load) q  <= mem[fetch_ptr[AW-1:0]];
      rdempty      <= ~head_vld_n;
      rdusedw      <= rdusedw_n;
      wrusedw      <= wrusedw_n;
      wrfull       <= (wrusedw_n == DEPTH_U);
      almost_full  <= (wrusedw_n >= AF_U);
      almost_empty <= (rdusedw_n <= AE_U);
      overflow     <= overflow_n;
      if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end

endmodule
